// File: rtl/router_wrap_coord_cfg_reg.sv
// Router tile coordinate configuration register bank.
// A serial chain shifts into a shadow register. A commit copies the shadow to the
// active coordinate outputs only after exactly TOTAL bits have been shifted in.
module router_wrap_coord_cfg_reg #(
   parameter int unsigned          COORD_W    = 4,
   parameter int unsigned          NUM_FIELDS = 2,
   parameter logic [COORD_W-1:0]   RESET_VAL  = '0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cfg_en,
   input  logic                            cfg_din,
   output logic                            cfg_dout,
   input  logic                            cfg_commit,
   input  logic                            cfg_abort,
   output logic [COORD_W*NUM_FIELDS-1:0]   coord_q,
   output logic                            coord_valid,
   output logic                            cfg_err
);

   localparam int unsigned        TOTAL     = COORD_W * NUM_FIELDS;
   localparam int unsigned        CNT_W     = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(TOTAL);
   localparam logic [TOTAL-1:0]   RESET_VEC = {NUM_FIELDS{RESET_VAL}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [TOTAL-1:0]   shadow_q, shadow_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [TOTAL-1:0]   coord_q_q, coord_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic [TOTAL:0]     shift_vec;

   // Concatenating the new bit on top and dropping bit 0 also works when TOTAL is 1.
   assign shift_vec = {cfg_din, shadow_q};

   // Register all state; reset restores the idle load sequence and the reset coordinates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         shadow_q  <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         coord_q_q <= RESET_VEC;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         coord_q_q <= coord_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic; abort outranks commit, which outranks shift.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      coord_d  = coord_q_q;
      valid_d  = valid_q;
      err_d    = err_q;

      if (cfg_abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         err_d   = 1'b0;
      end else if (cfg_commit) begin
         // Any commit ends the load sequence. Only a full, non-overflowed load is accepted.
         state_d = ST_IDLE;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         if (state_q == ST_FULL && !ovf_q) begin
            coord_d = shadow_q;
            valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end else if (cfg_en) begin
         shadow_d = shift_vec[TOTAL:1];
         unique case (state_q)
            ST_IDLE: begin
               cnt_d   = CNT_W'(1);
               state_d = (CNT_FULL == CNT_W'(1)) ? ST_FULL : ST_SHIFT;
            end
            ST_SHIFT: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == CNT_FULL) begin
                  state_d = ST_FULL;
               end
            end
            ST_FULL: begin
               // Data keeps passing down the chain, but the load is now invalid.
               ovf_d = 1'b1;
               err_d = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign cfg_dout    = shadow_q[0];
   assign coord_q     = coord_q_q;
   assign coord_valid = valid_q;
   assign cfg_err     = err_q;

endmodule
